// File: rtl/pulse_count_sequencer.sv
// pulse_count_sequencer: clears, times and reads out the pulse-counter array (cnt_clr/cnt_start/cnt_sel/cnt_data) as a 53-word tx_data/tx_valid/tx_ready frame, with acq_req/acq_abort control and acq_busy/acq_err/frame_cnt status
module pulse_count_sequencer #(
    parameter int          NUM_WORDS   = 52,
    parameter int          CNT_W       = 10,
    parameter int          CLR_CYCLES  = 2,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
    input  logic             clk50,
    input  logic             rst,
    input  logic             acq_req,
    input  logic             acq_abort,
    input  logic             cnt_done,
    output logic             cnt_clr,
    output logic             cnt_start,
    output logic [5:0]       cnt_sel,
    input  logic [CNT_W-1:0] cnt_data,
    output logic [15:0]      tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             acq_busy,
    output logic             acq_err,
    output logic [15:0]      frame_cnt
);
    typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, HDR, FETCH, SEND, DONE} state_t;
    state_t      state, state_n;
    logic [7:0]  clr_cnt, clr_n;
    logic [23:0] tcnt, tcnt_n;
    logic [5:0]  sel_n;
    logic [15:0] data_n, frame_n;
    logic        valid_n, err_n, xfer;
    assign xfer = tx_valid & tx_ready;
    always_comb begin
        state_n = state;
        clr_n   = '0;
        tcnt_n  = '0;
        sel_n   = cnt_sel;
        data_n  = tx_data;
        valid_n = tx_valid;
        err_n   = acq_err;
        frame_n = frame_cnt;
        unique case (state)
            IDLE: if (acq_req) begin
                state_n = CLEAR;
                err_n   = 1'b0;
            end
            CLEAR: begin
                clr_n   = clr_cnt + 8'd1;
                state_n = clr_cnt == 8'(CLR_CYCLES - 1) ? COLLECT : CLEAR;
            end
            COLLECT: begin
                tcnt_n = tcnt + 24'd1;
                if (cnt_done) begin
                    state_n = HDR;
                    data_n  = {8'hA5, frame_cnt[7:0]};
                    valid_n = 1'b1;
                end else if (tcnt == TIMEOUT_CYC - 24'd1) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
            end
            HDR: if (xfer) begin
                state_n = FETCH;
                valid_n = 1'b0;
                sel_n   = '0;
            end
            FETCH: begin
                data_n  = 16'({cnt_sel, cnt_data});
                valid_n = 1'b1;
                state_n = SEND;
            end
            SEND: if (xfer) begin
                valid_n = 1'b0;
                state_n = cnt_sel == 6'(NUM_WORDS - 1) ? DONE : FETCH;
                sel_n   = cnt_sel == 6'(NUM_WORDS - 1) ? cnt_sel : cnt_sel + 6'd1;
            end
            DONE: begin
                frame_n = frame_cnt + 16'd1;
                sel_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (acq_abort) begin
            state_n = IDLE;
            valid_n = 1'b0;
            sel_n   = '0;
            clr_n   = '0;
            tcnt_n  = '0;
            err_n   = acq_err;
            frame_n = frame_cnt;
        end
    end
    always_ff @(posedge clk50) begin
        if (rst) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            tcnt      <= '0;
            cnt_sel   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            acq_err   <= 1'b0;
            frame_cnt <= '0;
            cnt_clr   <= 1'b0;
            cnt_start <= 1'b0;
            acq_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            clr_cnt   <= clr_n;
            tcnt      <= tcnt_n;
            cnt_sel   <= sel_n;
            tx_data   <= data_n;
            tx_valid  <= valid_n;
            acq_err   <= err_n;
            frame_cnt <= frame_n;
            cnt_clr   <= state_n == CLEAR;
            cnt_start <= state_n == COLLECT;
            acq_busy  <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_pulse_count_sequencer.sv
// tb_pulse_count_sequencer: scoreboard and vector-table bench for pulse_count_sequencer
module tb_pulse_count_sequencer;
    localparam int DONE_DLY = 100;
    typedef struct {
        bit rnd;
        int abort_sel;
        bit stray;
        int exp_xfers;
    } vec_t;
    logic        clk50 = 0;
    logic        rst = 1;
    logic        acq_req = 0, acq_abort = 0, cnt_done = 0, tx_ready = 0;
    logic        cnt_clr, cnt_start, tx_valid, acq_busy, acq_err;
    logic [5:0]  cnt_sel;
    logic [9:0]  cnt_data;
    logic [15:0] tx_data, frame_cnt;
    logic        t_req = 0, t_done = 0, t_abort = 0, t_ready = 1;
    logic        t_clr, t_start, t_valid, t_busy, t_err;
    logic [5:0]  t_sel;
    logic [9:0]  t_data;
    logic [15:0] t_txd, t_frame;
    int          checks = 0, failures = 0;
    int          clr_hi, start_hi, win, xfers, t_clr_hi, t_start_hi, t_valid_hi;
    logic        hold = 0;
    logic [15:0] hold_data;
    logic [15:0] exp_frame = 0;
    logic [15:0] sbq[$];
    vec_t        vecs[5];
    always #10 clk50 = ~clk50;
    function automatic logic [9:0] model(input logic [5:0] s);
        return {s[3:0], ~s} ^ 10'h155;
    endfunction
    assign cnt_data = model(cnt_sel);
    assign t_data   = model(t_sel);
    pulse_count_sequencer dut (
        .clk50(clk50), .rst(rst), .acq_req(acq_req), .acq_abort(acq_abort),
        .cnt_done(cnt_done), .cnt_clr(cnt_clr), .cnt_start(cnt_start), .cnt_sel(cnt_sel),
        .cnt_data(cnt_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .acq_busy(acq_busy), .acq_err(acq_err), .frame_cnt(frame_cnt)
    );
    pulse_count_sequencer #(.TIMEOUT_CYC(24'd16)) u_to (
        .clk50(clk50), .rst(rst), .acq_req(t_req), .acq_abort(t_abort),
        .cnt_done(t_done), .cnt_clr(t_clr), .cnt_start(t_start), .cnt_sel(t_sel),
        .cnt_data(t_data), .tx_data(t_txd), .tx_valid(t_valid), .tx_ready(t_ready),
        .acq_busy(t_busy), .acq_err(t_err), .frame_cnt(t_frame)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk50);
        #1;
    endtask
    task automatic push_frame();
        sbq.push_back({8'hA5, exp_frame[7:0]});
        for (int s = 0; s < 52; s++) sbq.push_back({6'(s), model(6'(s))});
    endtask
    always @(negedge clk50) begin
        if (rst) begin
            hold = 0;
        end else begin
            if (acq_req && !acq_busy) begin
                clr_hi = 0; start_hi = 0; win = 0; xfers = 0;
            end
            if (t_req && !t_busy) begin
                t_clr_hi = 0; t_start_hi = 0; t_valid_hi = 0;
            end
            clr_hi     += int'(cnt_clr);
            start_hi   += int'(cnt_start);
            win        += int'(cnt_start);
            t_clr_hi   += int'(t_clr);
            t_start_hi += int'(t_start);
            t_valid_hi += int'(t_valid);
            if (hold) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(hold_data));
            end
            if (tx_valid && tx_ready) begin
                xfers++;
                if (sbq.size() == 0) chk("extra_word", 32'(tx_data), 32'hFFFF_FFFF);
                else chk("word", 32'(tx_data), 32'(sbq.pop_front()));
            end
            hold      = tx_valid && !tx_ready && !acq_abort;
            hold_data = tx_data;
        end
    end
    task automatic run_acq(input vec_t v);
        int  n;
        bit  aborted;
        push_frame();
        cnt_done = 0;
        acq_req  = 1;
        tick();
        acq_req = 0;
        n = 0;
        aborted = 0;
        while (acq_busy && n < 4000) begin
            tx_ready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cnt_done  = win >= DONE_DLY;
            acq_abort = 0;
            acq_req   = 0;
            if (tx_valid && cnt_sel == 6'(v.abort_sel) && !aborted) begin
                acq_abort = 1;
                tx_ready  = 0;
                aborted   = 1;
            end
            if (v.stray && ((cnt_start && win == 50) || (tx_valid && cnt_sel == 6'd30))) acq_req = 1;
            tick();
            n++;
            if (acq_abort) begin
                acq_abort = 0;
                @(negedge clk50);
                chk("abort_valid", 32'(tx_valid), 32'd0);
                chk("abort_busy", 32'(acq_busy), 32'd0);
                chk("abort_sel", 32'(cnt_sel), 32'd0);
                chk("abort_start", 32'(cnt_start), 32'd0);
            end
        end
        acq_req = 0;
        tx_ready = 1;
        chk("frame_bound", 32'(n < 4000), 32'd1);
        if (v.exp_xfers == 53) exp_frame++;
        @(negedge clk50);
        chk("xfers", 32'(xfers), 32'(v.exp_xfers));
        chk("sb_left", 32'(sbq.size()), 32'(53 - v.exp_xfers));
        chk("clr_cycles", 32'(clr_hi), 32'd2);
        chk("start_cycles", 32'(start_hi), 32'(DONE_DLY + 1));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_frame));
        chk("err_clear", 32'(acq_err), 32'd0);
        sbq.delete();
        repeat (3) tick();
        chk("idle_after", 32'(acq_busy), 32'd0);
    endtask
    initial begin
        int n;
        vecs[0] = '{rnd: 0, abort_sel: -1, stray: 0, exp_xfers: 53};
        vecs[1] = '{rnd: 1, abort_sel: -1, stray: 0, exp_xfers: 53};
        vecs[2] = '{rnd: 0, abort_sel: 20, stray: 0, exp_xfers: 21};
        vecs[3] = '{rnd: 0, abort_sel: -1, stray: 0, exp_xfers: 53};
        vecs[4] = '{rnd: 0, abort_sel: -1, stray: 1, exp_xfers: 53};
        repeat (3) tick();
        rst = 0;
        @(negedge clk50);
        chk("rst_clr", 32'(cnt_clr), 32'd0);
        chk("rst_start", 32'(cnt_start), 32'd0);
        chk("rst_sel", 32'(cnt_sel), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(acq_busy), 32'd0);
        chk("rst_err", 32'(acq_err), 32'd0);
        chk("rst_frame", 32'(frame_cnt), 32'd0);
        foreach (vecs[i]) run_acq(vecs[i]);
        t_req = 1;
        tick();
        t_req = 0;
        n = 0;
        while (t_busy && n < 200) begin tick(); n++; end
        @(negedge clk50);
        chk("to_bound", 32'(n < 200), 32'd1);
        chk("to_err", 32'(t_err), 32'd1);
        chk("to_collect", 32'(t_start_hi), 32'd16);
        chk("to_clr", 32'(t_clr_hi), 32'd2);
        chk("to_no_valid", 32'(t_valid_hi), 32'd0);
        chk("to_frame", 32'(t_frame), 32'd0);
        repeat (3) tick();
        chk("to_err_sticky", 32'(t_err), 32'd1);
        t_req = 1;
        tick();
        t_req = 0;
        @(negedge clk50);
        chk("to_err_cleared", 32'(t_err), 32'd0);
        n = 0;
        while (t_busy && n < 200) begin tick(); n++; end
        force dut.frame_cnt = 16'hFFFF;
        repeat (2) tick();
        release dut.frame_cnt;
        exp_frame = 16'hFFFF;
        run_acq(vecs[0]);
        run_acq(vecs[0]);
        push_frame();
        acq_req = 1;
        tick();
        acq_req = 0;
        n = 0;
        while (!(tx_valid && cnt_sel == 6'd5) && n < 1000) begin
            cnt_done = win >= DONE_DLY;
            tick();
            n++;
        end
        chk("mid_bound", 32'(n < 1000), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk50);
        chk("mid_rst_frame", 32'(frame_cnt), 32'd0);
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_busy", 32'(acq_busy), 32'd0);
        chk("mid_rst_sel", 32'(cnt_sel), 32'd0);
        sbq.delete();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
